// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmitter state encoding and the
// default bit period. Also intended for the matching receiver.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push strobe from the bridge reply path into the transmitter.
// There is no back-pressure: the producer simply strobes send with a byte.
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_dat;
    logic                 send;

    modport master (output tx_dat, output send);
    modport slave  (input  tx_dat, input  send);
endinterface

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with registered count/full/empty flags and a
// combinational head read so a pop can load the head on the same edge.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CNT_W-1:0] w_count_next;

    // Fullness/emptiness are judged on the registered (pre-edge) state only.
    assign w_push_ok    = i_push && !r_full;
    assign w_pop_ok     = i_pop  && !r_empty;
    assign w_count_next = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);

    // Storage array: write-only on push, no reset needed for the data itself.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally; flags are registered from the next count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter (LSB first) fed by the bridge reply path.
// Bytes queue in a small FIFO; a push while full is dropped and flagged.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           i_wb_clk,
    input  logic           i_wb_rst_n,
    uart_tx_fifo_if.slave  s_tx,
    output logic           o_tx,
    output logic           o_busy,
    output logic           o_full,
    output logic           o_overflow
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_idx;
    logic [BAUD_W-1:0]    r_baud;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_overflow;

    logic [DATA_BITS-1:0] w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CNT_W-1:0]     w_fifo_count;
    logic                 w_pop;
    logic                 w_active_next;
    logic                 w_push_ok;
    logic [CNT_W-1:0]     w_count_next;
    logic                 w_baud_zero;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_wb_clk),
        .i_rst_n (i_wb_rst_n),
        .i_push  (s_tx.send),
        .i_wdata (s_tx.tx_dat),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_baud_zero  = (r_baud == '0);
    assign w_push_ok    = s_tx.send && !w_fifo_full;
    assign w_count_next = w_fifo_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);

    // Pop decision and whether the FSM will be out of IDLE after this edge.
    always_comb begin
        w_pop         = 1'b0;
        w_active_next = 1'b1;
        case (r_state)
            IDLE: begin
                w_pop         = !w_fifo_empty;
                w_active_next = !w_fifo_empty;
            end
            STOP: begin
                w_pop         = w_baud_zero && !w_fifo_empty;
                w_active_next = !(w_baud_zero && w_fifo_empty);
            end
            default: ;
        endcase
    end

    // Frame sequencer; o_tx is registered alongside every state change.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_baud    <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_fifo_empty) begin
                        r_shift <= w_fifo_rdata;
                        r_baud  <= BAUD_LOAD;
                        r_state <= START;
                        r_tx    <= 1'b0;
                    end
                end
                START: begin
                    if (w_baud_zero) begin
                        r_baud    <= BAUD_LOAD;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_zero) begin
                        r_shift <= r_shift >> 1;
                        r_baud  <= BAUD_LOAD;
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_zero) begin
                        if (!w_fifo_empty) begin
                            // Next byte already waiting: chain straight into its start bit.
                            r_shift <= w_fifo_rdata;
                            r_baud  <= BAUD_LOAD;
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Registered status: busy reflects post-edge FSM/FIFO state, overflow is a pulse.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_busy     <= w_active_next || (w_count_next != '0);
            r_overflow <= s_tx.send && w_fifo_full;
        end
    end

    assign o_tx       = r_tx;
    assign o_busy     = r_busy;
    assign o_full     = w_fifo_full;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-position model (queue plus
// cycle offset within the current 10-bit frame) is compared every cycle, a
// line decoder recovers bytes from o_tx, and directed scenarios pin literals.
module tb_uart_tx_fifo;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int FRAME = 10 * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic o_tx, o_busy, o_full, o_overflow;

    uart_tx_fifo_if bus();

    uart_tx_fifo #(.CLKS_PER_BIT(N), .FIFO_DEPTH(D)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .s_tx       (bus.slave),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    logic [7:0] m_cur;
    bit         m_active;
    int         m_t;
    bit         m_ovf;

    // line decoder state
    logic [7:0] d_bytes[$];
    logic [7:0] d_sh;
    bit         d_on;
    int         d_k;
    int         ovf_pulses;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_t / N;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_sent.delete();
        m_active = 0;
        m_t      = 0;
        m_ovf    = 0;
    endtask

    task automatic model_step();
        int pre;
        pre   = m_q.size();
        m_ovf = bus.send && (pre == D);
        if (!m_active) begin
            if (pre > 0) begin
                m_cur = m_q.pop_front(); m_sent.push_back(m_cur);
                m_active = 1; m_t = 0;
            end
        end else if (m_t == FRAME - 1) begin
            if (pre > 0) begin
                m_cur = m_q.pop_front(); m_sent.push_back(m_cur);
                m_t = 0;
            end else begin
                m_active = 0;
            end
        end else begin
            m_t++;
        end
        if (bus.send && pre < D) m_q.push_back(bus.tx_dat);
    endtask

    // model advances on each edge; async reset clears it at once
    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clear();
            else        model_step();
        end
    end

    // per-cycle compare plus serial decoder, sampled on the falling edge
    initial begin
        ovf_pulses = 0;
        d_on = 0; d_k = 0; d_sh = '0;
        forever begin
            @(negedge clk);
            chk("tx",       32'(o_tx),       32'(exp_tx()));
            chk("busy",     32'(o_busy),     32'(m_active || m_q.size() > 0));
            chk("full",     32'(o_full),     32'(m_q.size() == D));
            chk("overflow", 32'(o_overflow), 32'(m_ovf));
            if (o_overflow === 1'b1) ovf_pulses++;
            if (!rst_n) begin
                d_on = 0;
            end else if (!d_on) begin
                if (o_tx === 1'b0) begin d_on = 1; d_k = 0; end
            end else begin
                d_k++;
                if ((d_k % N) == 1 && d_k / N >= 1 && d_k / N <= 8) d_sh[d_k/N-1] = o_tx;
                if (d_k == 9 * N + 1) begin
                    chk("stop_bit", 32'(o_tx), 32'd1);
                    d_bytes.push_back(d_sh);
                    $display("frame %0d byte %02h at %0t", d_bytes.size(), d_sh, $time);
                    d_on = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        d_bytes.delete();
        m_sent.delete();
        ovf_pulses = 0;
    endtask

    // called at a falling edge; returns at the falling edge after the sampling edge
    task automatic push1(input logic [7:0] b);
        bus.send = 1'b1; bus.tx_dat = b;
        @(negedge clk);
        bus.send = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (o_busy && c < 2000) begin @(negedge clk); c++; end
        chk("drain_timeout", 32'(c < 2000), 32'd1);
        tick(2);
    endtask

    logic [7:0] bytes9 [9];
    bit         a5_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        bus.send = 1'b0; bus.tx_dat = '0;
        tick(3);
        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // single byte 0xA5: start low from E+1, LSB first, busy drops at E+41
        clear_logs();
        push1(8'hA5);
        tick(1);  chk("a5_start_first", 32'(o_tx), 32'd0);
        tick(3);  chk("a5_start_last", 32'(o_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1); chk("a5_bit", 32'(o_tx), 32'(a5_bits[i]));
            tick(3); chk("a5_bit_end", 32'(o_tx), 32'(a5_bits[i]));
        end
        tick(1);  chk("a5_stop", 32'(o_tx), 32'd1);
        tick(3);  chk("a5_busy_j40", 32'(o_busy), 32'd1);
        tick(1);  chk("a5_busy_j41", 32'(o_busy), 32'd0);
        chk("a5_nframes", 32'(d_bytes.size()), 32'd1);
        if (d_bytes.size() > 0) chk("a5_byte", 32'(d_bytes[0]), 32'hA5);
        tick(3);

        // bridge reply pair with one idle edge between pushes: 80 contiguous clocks
        clear_logs();
        push1(8'h34);
        tick(1);
        push1(8'h46);
        tick(78); chk("pair_busy_j80", 32'(o_busy), 32'd1);
        tick(1);  chk("pair_busy_j81", 32'(o_busy), 32'd0);
        chk("pair_nframes", 32'(d_bytes.size()), 32'd2);
        if (d_bytes.size() == 2) begin
            chk("pair_b0", 32'(d_bytes[0]), 32'h34);
            chk("pair_b1", 32'(d_bytes[1]), 32'h46);
        end
        tick(3);

        // six consecutive pushes into depth 4: sixth byte dropped
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            bus.send = 1'b1; bus.tx_dat = 8'(8'h10 + i);
            @(negedge clk);
            if (i == 4) chk("ovf_full", 32'(o_full), 32'd1);
        end
        bus.send = 1'b0;
        chk("ovf_pulse", 32'(o_overflow), 32'd1);
        tick(1);
        chk("ovf_single", 32'(o_overflow), 32'd0);
        wait_idle();
        chk("ovf_pulses", 32'(ovf_pulses), 32'd1);
        chk("ovf_nframes", 32'(d_bytes.size()), 32'd5);
        for (int i = 0; i < 5 && i < d_bytes.size(); i++)
            chk("ovf_byte", 32'(d_bytes[i]), 32'(8'h10 + i));

        // nine bytes, never filling the FIFO; pointers wrap twice
        clear_logs();
        for (int i = 0; i < 9; i++) begin
            bytes9[i] = 8'($urandom);
            push1(bytes9[i]);
            tick(30 + $urandom_range(0, 10));
        end
        wait_idle();
        chk("wrap_nframes", 32'(d_bytes.size()), 32'd9);
        for (int i = 0; i < 9 && i < d_bytes.size(); i++)
            chk("wrap_byte", 32'(d_bytes[i]), 32'(bytes9[i]));

        // reset during a data bit with two bytes queued; send ignored while in reset
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            bus.send = 1'b1; bus.tx_dat = 8'(8'h60 + i);
            @(negedge clk);
        end
        bus.send = 1'b0;
        tick(10);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_tx", 32'(o_tx), 32'd1);
        chk("rstmid_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        bus.send = 1'b1; bus.tx_dat = 8'h77;
        tick(3);
        bus.send = 1'b0;
        rst_n = 1'b1;
        tick(100);
        chk("rstmid_idle", 32'(o_busy), 32'd0);
        chk("rstmid_nframes", 32'(d_bytes.size()), 32'd0);

        // push sampled on the final stop-bit edge with the FIFO empty
        clear_logs();
        push1(8'h5A);
        tick(40);
        push1(8'hC3);
        chk("stoppush_gap", 32'(o_tx), 32'd1);
        tick(1);
        chk("stoppush_start", 32'(o_tx), 32'd0);
        wait_idle();
        chk("stoppush_nframes", 32'(d_bytes.size()), 32'd2);
        if (d_bytes.size() == 2) begin
            chk("stoppush_b0", 32'(d_bytes[0]), 32'h5A);
            chk("stoppush_b1", 32'(d_bytes[1]), 32'hC3);
        end

        // randomized singles and bursts
        clear_logs();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                for (int k = 0; k < 5; k++) begin
                    bus.send = 1'b1; bus.tx_dat = 8'($urandom);
                    @(negedge clk);
                end
                bus.send = 1'b0;
            end else begin
                bus.send = (r < 6); bus.tx_dat = 8'($urandom);
                @(negedge clk);
                bus.send = 1'b0;
            end
        end
        bus.send = 1'b0;
        wait_idle();
        chk("rand_nframes", 32'(d_bytes.size()), 32'(m_sent.size()));
        for (int i = 0; i < d_bytes.size() && i < m_sent.size(); i++)
            chk("rand_byte", 32'(d_bytes[i]), 32'(m_sent[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
